// File: rtl/u712_chipset_cycle_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : u712_chipset_cycle_sequencer_pkg                                |
// | Brief  : Shared encodings and per-word-cycle decode helpers for the      |
// |          chipset cycle sequencer.                                        |
// | Rev    : 1.0  initial release                                            |
// ---------------------------------------------------------------------------
package u712_chipset_cycle_sequencer_pkg;

  // CPU SIZ encodings (68040)
  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  // Per-cycle size handed to the byte-enable block
  localparam logic [1:0] CSIZ_NONE = 2'b00;
  localparam logic [1:0] CSIZ_BYTE = 2'b01;
  localparam logic [1:0] CSIZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STROBE   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ABORT    = 3'd5
  } seq_state_t;

  // Number of 16-bit chipset cycles one CPU transfer expands into.
  function automatic logic [3:0] word_count(input logic [1:0] siz);
    logic [3:0] n;
    case (siz)
      SIZ_BYTE: n = 4'd1;
      SIZ_WORD: n = 4'd1;
      SIZ_LONG: n = 4'd2;
      default:  n = 4'd8;
    endcase
    return n;
  endfunction

  // Chipset address of the current word cycle. Long/line cycles walk
  // longword index lw (mod 4) and the half within it (0 = high word).
  function automatic logic [3:0] cycle_addr(input logic [1:0] siz, input logic [3:0] a,
                                            input logic [1:0] lw, input logic half);
    logic [3:0] r;
    case (siz)
      SIZ_BYTE: r = a;
      SIZ_WORD: r = {a[3:1], 1'b0};
      default:  r = {lw, half, 1'b0};
    endcase
    return r;
  endfunction

  // CPU data lane: high word lives at even word offsets.
  function automatic logic cycle_hi(input logic [1:0] siz, input logic [3:0] a,
                                    input logic half);
    logic r;
    if (siz == SIZ_BYTE || siz == SIZ_WORD) r = ~a[1];
    else r = ~half;
    return r;
  endfunction

  function automatic logic [1:0] cycle_size(input logic [1:0] siz);
    return (siz == SIZ_BYTE) ? CSIZ_BYTE : CSIZ_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/u712_chipset_cycle_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : u712_chipset_cycle_sequencer_if                                 |
// | Brief  : CPU-request / chipset-cycle signal bundle for the sequencer.    |
// | Rev    : 1.0  initial release                                            |
// ---------------------------------------------------------------------------
interface u712_chipset_cycle_sequencer_if;
  logic       req;
  logic [3:0] a;
  logic [1:0] siz;
  logic       chip_ack;
  logic [3:0] chip_a;
  logic [1:0] chip_siz;
  logic       ds_en;
  logic       hi_word;
  logic       cpu_ta;
  logic       cpu_tea;
  logic       busy;

  // master: CPU decode / chipset timing side driving requests and acks
  modport master (
    output req, a, siz, chip_ack,
    input  chip_a, chip_siz, ds_en, hi_word, cpu_ta, cpu_tea, busy
  );

  // slave: the sequencer itself
  modport slave (
    input  req, a, siz, chip_ack,
    output chip_a, chip_siz, ds_en, hi_word, cpu_ta, cpu_tea, busy
  );
endinterface
`default_nettype wire

// File: rtl/u712_cycle_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : u712_cycle_timeout                                              |
// | Brief  : 8-bit clear/enable counter flagging the cycle on which the      |
// |          count reaches TIMEOUT_CYCLES.                                   |
// | Rev    : 1.0  initial release                                            |
// ---------------------------------------------------------------------------
module u712_cycle_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // Count enabled cycles; saturate so a stuck enable never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) count <= 8'd0;
    else if (enable && count != 8'hFF) count <= count + 8'd1;
  end

  // Flags the enabled cycle whose increment brings the count to the limit.
  assign expired = enable && (({1'b0, count} + 9'd1) == 9'(TIMEOUT_CYCLES));

endmodule
`default_nettype wire

// File: rtl/u712_chipset_cycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : u712_chipset_cycle_sequencer                                    |
// | Brief  : Splits one 68040 chipset-space transfer into 16-bit chipset     |
// |          word cycles, sequences DS_EN and returns TA/TEA to the CPU.     |
// | Rev    : 1.0  initial release                                            |
// ---------------------------------------------------------------------------
module u712_chipset_cycle_sequencer
  import u712_chipset_cycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                                clk40,
  input  logic                                reset,
  u712_chipset_cycle_sequencer_if.slave       bus
);

  localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  seq_state_t state, next_state;

  // Latched request and walking counters
  logic [3:0] a_q, a_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] lw_q, lw_d;
  logic       half_q, half_d;
  logic [3:0] words_q, words_d;
  logic [1:0] gap_q, gap_d;

  // Registered outputs
  logic [3:0] chip_a_q, chip_a_d;
  logic [1:0] chip_siz_q, chip_siz_d;
  logic       hi_word_q, hi_word_d;
  logic       ds_en_q, ds_en_d;
  logic       ta_q, ta_d;
  logic       tea_q, tea_d;
  logic       busy_q, busy_d;

  logic       expired;

  u712_cycle_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk40),
    .rst     (reset),
    .clear   (state == ST_STROBE),
    .enable  (state == ST_WAIT_ACK),
    .expired (expired)
  );

  // State register plus all registered counters and outputs.
  always_ff @(posedge clk40) begin
    if (reset) begin
      state      <= ST_IDLE;
      a_q        <= 4'd0;
      siz_q      <= 2'd0;
      lw_q       <= 2'd0;
      half_q     <= 1'b0;
      words_q    <= 4'd0;
      gap_q      <= 2'd0;
      chip_a_q   <= 4'd0;
      chip_siz_q <= CSIZ_NONE;
      hi_word_q  <= 1'b0;
      ds_en_q    <= 1'b0;
      ta_q       <= 1'b0;
      tea_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= next_state;
      a_q        <= a_d;
      siz_q      <= siz_d;
      lw_q       <= lw_d;
      half_q     <= half_d;
      words_q    <= words_d;
      gap_q      <= gap_d;
      chip_a_q   <= chip_a_d;
      chip_siz_q <= chip_siz_d;
      hi_word_q  <= hi_word_d;
      ds_en_q    <= ds_en_d;
      ta_q       <= ta_d;
      tea_q      <= tea_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state decode; an ack on the expiry cycle takes priority over abort.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (bus.req) next_state = ST_STROBE;
      ST_STROBE:   next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (bus.chip_ack) begin
          if (words_q == 4'd1)      next_state = ST_DONE;
          else if (GAP_CYCLES == 0) next_state = ST_STROBE;
          else                      next_state = ST_GAP;
        end else if (expired) begin
          next_state = ST_ABORT;
        end
      end
      ST_GAP:      if (gap_q == GAP_LAST) next_state = ST_STROBE;
      ST_DONE:     next_state = ST_IDLE;
      ST_ABORT:    next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Counter updates and next output values. The cycle address/lane/size
  // only load on entry to STROBE, so they stay frozen while DS_EN is high.
  always_comb begin
    a_d        = a_q;
    siz_d      = siz_q;
    lw_d       = lw_q;
    half_d     = half_q;
    words_d    = words_q;
    gap_d      = 2'd0;
    chip_a_d   = chip_a_q;
    chip_siz_d = chip_siz_q;
    hi_word_d  = hi_word_q;
    ta_d       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          a_d     = bus.a;
          siz_d   = bus.siz;
          lw_d    = bus.a[3:2];
          half_d  = 1'b0;
          words_d = word_count(bus.siz);
        end
      end
      ST_WAIT_ACK: begin
        if (bus.chip_ack) begin
          words_d = words_q - 4'd1;
          half_d  = ~half_q;
          if (half_q) lw_d = lw_q + 2'd1;
          // A beat completes on every ack for byte/word, on the low half otherwise.
          ta_d = (siz_q == SIZ_BYTE) || (siz_q == SIZ_WORD) || half_q;
        end
      end
      ST_GAP:  gap_d = gap_q + 2'd1;
      default: ;
    endcase
    if (next_state == ST_STROBE) begin
      chip_a_d   = cycle_addr(siz_d, a_d, lw_d, half_d);
      chip_siz_d = cycle_size(siz_d);
      hi_word_d  = cycle_hi(siz_d, a_d, half_d);
    end
    ds_en_d = (next_state == ST_STROBE) || (next_state == ST_WAIT_ACK);
    tea_d   = (next_state == ST_ABORT);
    busy_d  = (next_state != ST_IDLE);
  end

  assign bus.chip_a   = chip_a_q;
  assign bus.chip_siz = chip_siz_q;
  assign bus.hi_word  = hi_word_q;
  assign bus.ds_en    = ds_en_q;
  assign bus.cpu_ta   = ta_q;
  assign bus.cpu_tea  = tea_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_u712_chipset_cycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : tb_u712_chipset_cycle_sequencer                                 |
// | Brief  : Self-checking bench: directed table, reset/stray sequences and  |
// |          randomized transfers against a transfer-level model.           |
// | Rev    : 1.0  initial release                                            |
// ---------------------------------------------------------------------------
module tb_u712_chipset_cycle_sequencer;
  import u712_chipset_cycle_sequencer_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int GAP     = 1;
  localparam int BUDGET  = 400;

  logic clk40 = 1'b0;
  logic reset = 1'b1;
  always #5 clk40 = ~clk40;

  u712_chipset_cycle_sequencer_if bus ();

  u712_chipset_cycle_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk40 (clk40),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Per-transfer stimulus and observations
  int         cur_dly [8];
  logic [3:0] obs_a   [8];
  logic       obs_hi  [8];
  logic [1:0] obs_sz  [8];
  int         obs_len [8];
  int obs_words, obs_ta, obs_tea, gap_bad, ta_bad, unstable, end_dist, finished;
  int exp_words, exp_ta, exp_tea;

  typedef struct {
    logic [3:0] a;
    logic [1:0] siz;
    int         dly;
    bit         stray;
    int         words;
    logic [3:0] first_a;
    logic [3:0] last_a;
    logic       first_hi;
    logic [1:0] csiz;
    int         ta;
    int         tea;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (transfer level) ----------------
  function automatic int mdl_total(input logic [1:0] s);
    if (s == SIZ_BYTE || s == SIZ_WORD) return 1;
    if (s == SIZ_LONG) return 2;
    return 8;
  endfunction

  function automatic int mdl_addr(input int a, input logic [1:0] s, input int i);
    if (s == SIZ_BYTE) return a;
    if (s == SIZ_WORD) return a - (a % 2);
    return (((a / 4) + (i / 2)) % 4) * 4 + (i % 2) * 2;
  endfunction

  function automatic int mdl_hi(input int a, input logic [1:0] s, input int i);
    if (s == SIZ_BYTE || s == SIZ_WORD) return ((a / 2) % 2 == 0) ? 1 : 0;
    return (i % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_xfer(input logic [1:0] s);
    int total;
    int acked;
    total = mdl_total(s);
    acked = 0;
    exp_tea = 0;
    exp_words = 0;
    for (int i = 0; i < total; i++) begin
      exp_words = i + 1;
      if (cur_dly[i] > TIMEOUT) begin
        exp_tea = 1;
        break;
      end
      acked++;
    end
    exp_ta = (s == SIZ_BYTE || s == SIZ_WORD) ? acked : acked / 2;
  endtask

  // ---------------- driver / monitor for one transfer ----------------
  task automatic run_xfer(input logic [3:0] xa, input logic [1:0] xs, input bit stray);
    int cyc, gap, ds_cnt, wi, last_pulse;
    logic prev_ds;
    obs_words = 0; obs_ta = 0; obs_tea = 0; gap_bad = 0; ta_bad = 0; unstable = 0;
    finished = 0; last_pulse = -100;
    for (int i = 0; i < 8; i++) begin
      obs_a[i] = 4'd0; obs_hi[i] = 1'b0; obs_sz[i] = 2'd0; obs_len[i] = 0;
    end
    if (stray) begin
      @(negedge clk40);
      bus.chip_ack = 1'b1;
      @(negedge clk40);
      bus.chip_ack = 1'b0;
      check("idle_ack_busy", bus.busy, 0);
    end
    @(negedge clk40);
    bus.req = 1'b1; bus.a = xa; bus.siz = xs; bus.chip_ack = 1'b0;
    @(negedge clk40);
    bus.req = 1'b0;
    prev_ds = 1'b0; ds_cnt = 0; gap = 0; wi = 0;
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      if (!bus.busy) begin
        finished = 1;
        break;
      end
      bus.chip_ack = 1'b0;
      bus.req = stray;
      if (bus.cpu_ta)  begin obs_ta++;  if (!prev_ds) ta_bad++; last_pulse = cyc; end
      if (bus.cpu_tea) begin obs_tea++; if (!prev_ds) ta_bad++; last_pulse = cyc; end
      if (bus.ds_en) begin
        if (!prev_ds) begin
          if (obs_words > 0 && gap != GAP) gap_bad++;
          obs_words++;
          wi = (obs_words > 8) ? 7 : obs_words - 1;
          obs_a[wi] = bus.chip_a; obs_hi[wi] = bus.hi_word; obs_sz[wi] = bus.chip_siz;
          ds_cnt = 0;
        end else if (bus.chip_a != obs_a[wi] || bus.hi_word != obs_hi[wi] ||
                     bus.chip_siz != obs_sz[wi]) begin
          unstable++;
        end
        ds_cnt++;
        obs_len[wi] = ds_cnt;
        if (ds_cnt == cur_dly[wi] + 1) bus.chip_ack = 1'b1;
        gap = 0;
      end else begin
        gap++;
        if (stray) bus.chip_ack = 1'b1;
      end
      prev_ds = bus.ds_en;
      @(negedge clk40);
    end
    bus.req = 1'b0; bus.chip_ack = 1'b0;
    end_dist = cyc - last_pulse;
    check("xfer_finished", finished, 1);
    @(negedge clk40);
    check("idle_after", {31'd0, bus.busy | bus.ds_en}, 0);
  endtask

  task automatic check_common();
    check("gap_len", gap_bad, 0);
    check("ta_after_ack", ta_bad, 0);
    check("stable_while_ds", unstable, 0);
    check("busy_drop_align", end_dist, 1);
  endtask

  initial begin
    bus.req = 1'b0; bus.a = 4'd0; bus.siz = 2'd0; bus.chip_ack = 1'b0;

    //                 a      siz       dly st words first last  hi csiz      ta tea
    tbl[0] = '{4'h3, SIZ_BYTE, 3,  0, 1, 4'h3, 4'h3, 0, CSIZ_BYTE, 1, 0};
    tbl[1] = '{4'h4, SIZ_LONG, 2,  0, 2, 4'h4, 4'h6, 1, CSIZ_WORD, 1, 0};
    tbl[2] = '{4'hC, SIZ_LINE, 1,  0, 8, 4'hC, 4'hA, 1, CSIZ_WORD, 4, 0};
    tbl[3] = '{4'h5, SIZ_WORD, 99, 0, 1, 4'h4, 4'h4, 1, CSIZ_WORD, 0, 1};
    tbl[4] = '{4'hA, SIZ_WORD, 15, 0, 1, 4'hA, 4'hA, 0, CSIZ_WORD, 1, 0};
    tbl[5] = '{4'h0, SIZ_LINE, 2,  1, 8, 4'h0, 4'hE, 1, CSIZ_WORD, 4, 0};
    tbl[6] = '{4'hE, SIZ_BYTE, 1,  1, 1, 4'hE, 4'hE, 0, CSIZ_BYTE, 1, 0};

    // Reset state
    repeat (3) @(negedge clk40);
    check("rst_chip_a",   bus.chip_a,   0);
    check("rst_chip_siz", bus.chip_siz, 0);
    check("rst_ds_en",    bus.ds_en,    0);
    check("rst_hi_word",  bus.hi_word,  0);
    check("rst_cpu_ta",   bus.cpu_ta,   0);
    check("rst_cpu_tea",  bus.cpu_tea,  0);
    check("rst_busy",     bus.busy,     0);
    reset = 1'b0;

    // Directed table
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 8; i++) cur_dly[i] = tbl[r].dly;
      run_xfer(tbl[r].a, tbl[r].siz, tbl[r].stray);
      check("tbl_words",    obs_words, tbl[r].words);
      check("tbl_first_a",  obs_a[0], tbl[r].first_a);
      check("tbl_last_a",   obs_a[(obs_words > 8 || obs_words < 1) ? 0 : obs_words - 1],
            tbl[r].last_a);
      check("tbl_first_hi", obs_hi[0], tbl[r].first_hi);
      check("tbl_chip_siz", obs_sz[0], tbl[r].csiz);
      check("tbl_ta",       obs_ta, tbl[r].ta);
      check("tbl_tea",      obs_tea, tbl[r].tea);
      check("tbl_len0",     obs_len[0], (tbl[r].dly > TIMEOUT) ? TIMEOUT + 1 : tbl[r].dly + 1);
      check_common();
    end

    // Reset during the second word cycle of a longword
    @(negedge clk40);
    bus.req = 1'b1; bus.a = 4'h4; bus.siz = SIZ_LONG;
    @(negedge clk40); bus.req = 1'b0;       // first STROBE
    @(negedge clk40);                        // WAIT 1
    @(negedge clk40); bus.chip_ack = 1'b1;   // WAIT 2, acked
    @(negedge clk40); bus.chip_ack = 1'b0;   // GAP
    @(negedge clk40);                        // second STROBE
    @(negedge clk40);                        // second WAIT
    check("rstmid_pre_ds", bus.ds_en, 1);
    check("rstmid_pre_a",  bus.chip_a, 6);
    reset = 1'b1;
    @(negedge clk40);
    check("rstmid_outs", {21'd0, bus.chip_a, bus.chip_siz, bus.ds_en, bus.hi_word,
                          bus.cpu_ta, bus.cpu_tea, bus.busy}, 0);
    reset = 1'b0;
    @(negedge clk40);
    check("rstmid_no_pulse", {30'd0, bus.cpu_ta, bus.cpu_tea}, 0);
    for (int i = 0; i < 8; i++) cur_dly[i] = 2;
    run_xfer(4'h1, SIZ_BYTE, 1'b0);
    check("rstmid_new_words", obs_words, 1);
    check("rstmid_new_ta", obs_ta, 1);

    // Randomized transfers against the model
    for (int t = 0; t < 30; t++) begin
      logic [3:0] ra;
      logic [1:0] rs;
      bit         rst_y;
      int         sel;
      ra = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      rst_y = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        sel = $urandom_range(0, 11);
        if (sel == 0)      cur_dly[i] = $urandom_range(TIMEOUT + 1, TIMEOUT + 3);
        else if (sel == 1) cur_dly[i] = TIMEOUT;
        else               cur_dly[i] = $urandom_range(1, 5);
      end
      model_xfer(rs);
      run_xfer(ra, rs, rst_y);
      check("rnd_words", obs_words, exp_words);
      check("rnd_ta", obs_ta, exp_ta);
      check("rnd_tea", obs_tea, exp_tea);
      for (int i = 0; i < exp_words; i++) begin
        check("rnd_addr", obs_a[i], mdl_addr(ra, rs, i));
        check("rnd_hi", obs_hi[i], mdl_hi(ra, rs, i));
        check("rnd_siz", obs_sz[i], (rs == SIZ_BYTE) ? 1 : 2);
        check("rnd_len", obs_len[i], (cur_dly[i] > TIMEOUT) ? TIMEOUT + 1 : cur_dly[i] + 1);
      end
      check_common();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
